display_scheduler: RTL and testbench
====================================

# display_scheduler

Time-shares the two 4-digit seven-segment buses of the range-hood front panel between the four display producers: power-on clock, cumulative work time, gesture countdown and cleaning reminder. It selects the owning source through a priority state machine and multiplexes that source's eight BCD digits onto the scanned outputs. It replaces the ad-hoc display mux in the top level and sits between the timer, mode and gesture blocks and the panel pins.

## Interface

**Parameters**
- SCAN_DIV, default 100000: clk cycles per scan position; must be ≥ 2.
- HOLD_SEC, default 5: sec_tick pulses for which the reminder owns the display; must be ≥ 1.

**Ports**
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- power_state  in  1  hood powered; when low the display is dark.
- sec_tick  in  1  one-cycle pulse, once per second.
- view_key  in  1  one-cycle pulse; toggles the base view between clock and work time.
- gesture_active  in  1  level; a gesture countdown is running.
- reminder  in  1  level; a cleaning reminder is raised (rising edge only is used).
- src_clock  in  32  digits of the power-on clock.
- src_work  in  32  digits of the work time.
- src_gesture  in  32  digits of the gesture countdown.
- src_remind  in  32  digits of the reminder.
- seg_hi  out  8  segments for digits 7..4, {a,b,c,d,e,f,g,dp}, active-high.
- seg_lo  out  8  segments for digits 3..0, same encoding.
- tub_sel  out  8  digit enables, active-high; bit i enables digit i.
- owner  out  2  current owner: 0 clock, 1 work, 2 gesture, 3 remind.
- remind_shown  out  1  one-cycle pulse when a reminder hold completes.

## Operation

**Digit data**
- Digit i of any source is src[4i+3:4i].
- Decode: 0→FC, 1→60, 2→DA, 3→F2, 4→66, 5→B6, 6→BE, 7→E0, 8→FE, 9→F6; A–E→02 ('-'); F→00 (blank).

**State machine (OFF, BASE, GESTURE, REMIND)**
- OFF: entered from any state, one cycle after power_state is low. On entry, pending, view_sel and the hold counter are cleared. Outputs are all 0. When power_state is high, go to BASE.
- BASE: owner = view_sel (0 or 1).
  - If pending, go to REMIND and load the hold counter with HOLD_SEC.
  - Else if gesture_active, go to GESTURE.
- GESTURE: owner = 2.
  - If pending, go to REMIND and load HOLD_SEC.
  - Else if gesture_active is low, go to BASE.
- REMIND: owner = 3.
  - Each sec_tick, except one arriving on the entry cycle, decrements the hold counter.
  - On the tick that takes the counter from 1 to 0: clear pending, pulse remind_shown, and go to GESTURE if gesture_active is high, else BASE.
  - A new reminder rising edge while in REMIND reloads HOLD_SEC.

**Pending and view select**
- pending is set by a reminder rising edge (registered reminder_d) while power_state is high. A rising edge seen while the power is off is discarded.
- view_key toggles view_sel in any non-OFF state, including during GESTURE and REMIND. The toggle applies even on a cycle where the state also changes.

**Scan**
- A divider counts 0..SCAN_DIV-1. At wrap, the position k (0..3) increments mod 4.
- In every cycle, the registered outputs are:
  - tub_sel = bits k and k+4 set.
  - seg_lo = decode(owner digit k).
  - seg_hi = decode(owner digit k+4).
- In OFF, the divider and k are held at 0.

## Timing

- Reset values: all outputs 0, state OFF, k = 0, divider 0, pending 0, view_sel 0.
- Outputs are registered, one cycle of latency from the owner and source data.
- An owner change is visible on seg and owner one cycle after the triggering input. The scan position is not disturbed.
- A full refresh takes 4·SCAN_DIV cycles.
- power_state falling mid-REMIND: go to OFF next cycle, with no remind_shown pulse.
- reminder and gesture_active rising in the same cycle from BASE: go to REMIND. After the hold, go to GESTURE if gesture_active is still high.
- reset asserted mid-operation returns every register to its reset value immediately, regardless of clk.

## Test plan

- Reset, then power_state=1, SCAN_DIV=2, src_clock=32'h0012_3456:
  - owner=0.
  - In cycle order, tub_sel shows 11, 22, 44, 88.
  - At k=0, seg_lo=BE ('6') and seg_hi=DA ('2').
- view_key pulse in BASE: owner goes 0→1 next cycle. A second pulse returns it to 0. Digit F in src_work gives seg=00.
- gesture_active=1: owner=2 next cycle. Dropping gesture_active returns owner to the current view_sel.
- reminder rises during GESTURE with HOLD_SEC=3: owner=3. After the 3rd sec_tick, remind_shown pulses once and owner returns to 2. A reminder re-rise after 2 ticks extends the hold to 3 more ticks.
- power_state dropped mid-REMIND: next cycle all outputs are 0 and there is no remind_shown pulse. A reminder rise while the power is off gives owner 0 at power-up, not 3.
- Asynchronous reset pulse between clock edges: outputs are 0 immediately.

Source files
------------

// File: rtl/display_scheduler.sv
// Front-panel display owner arbitration and 8-digit seven-segment scan.
// Priority: reminder hold > gesture countdown > base view (clock or work time).
module display_scheduler #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned HOLD_SEC = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power_state,
    input  logic        sec_tick,
    input  logic        view_key,
    input  logic        gesture_active,
    input  logic        reminder,
    input  logic [31:0] src_clock,
    input  logic [31:0] src_work,
    input  logic [31:0] src_gesture,
    input  logic [31:0] src_remind,
    output logic [7:0]  seg_hi,
    output logic [7:0]  seg_lo,
    output logic [7:0]  tub_sel,
    output logic [1:0]  owner,
    output logic        remind_shown
);

    localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HoldW = $clog2(HOLD_SEC + 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_SEC);

    typedef enum logic [1:0] {StOff, StBase, StGesture, StRemind} state_e;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             view_sel_q, view_sel_d;
    logic             reminder_q;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [1:0]       k_q, k_d;
    logic [7:0]       seg_hi_q, seg_hi_d;
    logic [7:0]       seg_lo_q, seg_lo_d;
    logic [7:0]       tub_sel_q, tub_sel_d;
    logic [1:0]       owner_q, owner_d;
    logic             remind_shown_q, remind_shown_d;
    logic             rise;
    logic             shown;
    logic [31:0]      src;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0:    s = 8'hFC;
            4'h1:    s = 8'h60;
            4'h2:    s = 8'hDA;
            4'h3:    s = 8'hF2;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'hB6;
            4'h6:    s = 8'hBE;
            4'h7:    s = 8'hE0;
            4'h8:    s = 8'hFE;
            4'h9:    s = 8'hF6;
            4'hF:    s = 8'h00;
            default: s = 8'h02;
        endcase
        return s;
    endfunction

    assign rise = reminder & ~reminder_q;

    // Owner FSM. A reminder edge in REMIND reloads the hold and wins over a same-cycle tick.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        view_sel_d = view_sel_q;
        hold_d     = hold_q;
        shown      = 1'b0;
        if (!power_state) begin
            state_d    = StOff;
            pending_d  = 1'b0;
            view_sel_d = 1'b0;
            hold_d     = '0;
        end else begin
            if (rise) begin
                pending_d = 1'b1;
            end
            if (view_key && (state_q != StOff)) begin
                view_sel_d = ~view_sel_q;
            end
            unique case (state_q)
                StOff: state_d = StBase;
                StBase, StGesture: begin
                    if (pending_d) begin
                        state_d = StRemind;
                        hold_d  = HoldLoad;
                    end else if (gesture_active) begin
                        state_d = StGesture;
                    end else begin
                        state_d = StBase;
                    end
                end
                StRemind: begin
                    if (rise) begin
                        hold_d = HoldLoad;
                    end else if (sec_tick) begin
                        if (hold_q == HoldW'(1)) begin
                            hold_d    = '0;
                            pending_d = 1'b0;
                            shown     = 1'b1;
                            state_d   = gesture_active ? StGesture : StBase;
                        end else begin
                            hold_d = hold_q - HoldW'(1);
                        end
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    // Outputs are computed from next-state values so an owner change shows one cycle later.
    always_comb begin
        div_d          = '0;
        k_d            = '0;
        owner_d        = '0;
        tub_sel_d      = '0;
        seg_lo_d       = '0;
        seg_hi_d       = '0;
        src            = '0;
        remind_shown_d = shown;
        if (state_d != StOff) begin
            if (div_q == DivLast) begin
                div_d = '0;
                k_d   = k_q + 2'd1;
            end else begin
                div_d = div_q + DivW'(1);
                k_d   = k_q;
            end
            case (state_d)
                StBase:    owner_d = {1'b0, view_sel_d};
                StGesture: owner_d = 2'd2;
                default:   owner_d = 2'd3;
            endcase
            case (owner_d)
                2'd0:    src = src_clock;
                2'd1:    src = src_work;
                2'd2:    src = src_gesture;
                default: src = src_remind;
            endcase
            tub_sel_d = 8'h11 << k_d;
            seg_lo_d  = seg_decode(src[{k_d, 2'b00} +: 4]);
            seg_hi_d  = seg_decode(src[{1'b1, k_d, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StOff;
            pending_q      <= 1'b0;
            view_sel_q     <= 1'b0;
            reminder_q     <= 1'b0;
            hold_q         <= '0;
            div_q          <= '0;
            k_q            <= '0;
            seg_hi_q       <= '0;
            seg_lo_q       <= '0;
            tub_sel_q      <= '0;
            owner_q        <= '0;
            remind_shown_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            view_sel_q     <= view_sel_d;
            reminder_q     <= reminder;
            hold_q         <= hold_d;
            div_q          <= div_d;
            k_q            <= k_d;
            seg_hi_q       <= seg_hi_d;
            seg_lo_q       <= seg_lo_d;
            tub_sel_q      <= tub_sel_d;
            owner_q        <= owner_d;
            remind_shown_q <= remind_shown_d;
        end
    end

    assign seg_hi       = seg_hi_q;
    assign seg_lo       = seg_lo_q;
    assign tub_sel      = tub_sel_q;
    assign owner        = owner_q;
    assign remind_shown = remind_shown_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: a behavioural model predicts every cycle's outputs.
module tb_display_scheduler;

    localparam int unsigned SD = 2;
    localparam int unsigned HS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        power_state = 1'b0;
    logic        sec_tick = 1'b0;
    logic        view_key = 1'b0;
    logic        gesture_active = 1'b0;
    logic        reminder = 1'b0;
    logic [31:0] src_clock = '0;
    logic [31:0] src_work = '0;
    logic [31:0] src_gesture = '0;
    logic [31:0] src_remind = '0;
    logic [7:0]  seg_hi;
    logic [7:0]  seg_lo;
    logic [7:0]  tub_sel;
    logic [1:0]  owner;
    logic        remind_shown;

    display_scheduler #(
        .SCAN_DIV(SD),
        .HOLD_SEC(HS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .power_state   (power_state),
        .sec_tick      (sec_tick),
        .view_key      (view_key),
        .gesture_active(gesture_active),
        .reminder      (reminder),
        .src_clock     (src_clock),
        .src_work      (src_work),
        .src_gesture   (src_gesture),
        .src_remind    (src_remind),
        .seg_hi        (seg_hi),
        .seg_lo        (seg_lo),
        .tub_sel       (tub_sel),
        .owner         (owner),
        .remind_shown  (remind_shown)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] tub;
        logic [1:0] own;
        logic       shown;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] dec_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00};

    // Model: 0 off, 1 base, 2 gesture, 3 reminder hold.
    int m_state = 0;
    bit m_pend = 0;
    bit m_view = 0;
    bit m_rprev = 0;
    int m_hold = 0;
    int m_div = 0;
    int m_k = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_state = 0; m_pend = 0; m_view = 0; m_rprev = 0;
            m_hold = 0; m_div = 0; m_k = 0;
            exp_q.delete();
        end else begin
            bit   rise;
            bit   shown;
            int   old;
            exp_t e;
            logic [31:0] s;
            rise    = reminder && !m_rprev;
            m_rprev = reminder;
            shown   = 0;
            old     = m_state;
            if (!power_state) begin
                m_state = 0; m_pend = 0; m_view = 0; m_hold = 0;
            end else begin
                if (old != 0 && view_key) m_view = !m_view;
                if (rise) m_pend = 1;
                if (old == 0) begin
                    m_state = 1;
                end else if (old == 1 || old == 2) begin
                    if (m_pend) begin
                        m_state = 3;
                        m_hold  = HS;
                    end else begin
                        m_state = gesture_active ? 2 : 1;
                    end
                end else begin
                    if (rise) begin
                        m_hold = HS;
                    end else if (sec_tick) begin
                        m_hold = m_hold - 1;
                        if (m_hold == 0) begin
                            m_pend  = 0;
                            shown   = 1;
                            m_state = gesture_active ? 2 : 1;
                        end
                    end
                end
            end
            if (m_state == 0) begin
                m_div = 0;
                m_k   = 0;
            end else if (m_div == SD - 1) begin
                m_div = 0;
                m_k   = (m_k + 1) % 4;
            end else begin
                m_div = m_div + 1;
            end
            e = '0;
            if (m_state != 0) begin
                e.own = (m_state == 1) ? 2'(m_view) : 2'(m_state);
                case (e.own)
                    2'd0:    s = src_clock;
                    2'd1:    s = src_work;
                    2'd2:    s = src_gesture;
                    default: s = src_remind;
                endcase
                e.lo    = dec_tab[(s >> (4 * m_k)) & 32'hF];
                e.hi    = dec_tab[(s >> (4 * (m_k + 4))) & 32'hF];
                e.tub   = 8'((1 << m_k) | (1 << (m_k + 4)));
                e.shown = shown;
            end
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(negedge clk or posedge reset);
        if (reset) begin
            #1;
            check("reset_seg_hi", int'(seg_hi), 0);
            check("reset_seg_lo", int'(seg_lo), 0);
            check("reset_tub_sel", int'(tub_sel), 0);
            check("reset_owner", int'(owner), 0);
            check("reset_remind_shown", int'(remind_shown), 0);
        end else if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("seg_hi", int'(seg_hi), int'(e.hi));
            check("seg_lo", int'(seg_lo), int'(e.lo));
            check("tub_sel", int'(tub_sel), int'(e.tub));
            check("owner", int'(owner), int'(e.own));
            check("remind_shown", int'(remind_shown), int'(e.shown));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            view_key = 1'b0;
            sec_tick = 1'b0;
        end
    endtask

    initial begin
        src_clock   = 32'h0012_3456;
        src_work    = 32'hF9F8_7F65;
        src_gesture = 32'h0000_0305;
        src_remind  = 32'hABCD_E0F1;
        power_state = 1'b1;
        #12 reset = 1'b0;
        tick(10);
        // view toggles
        view_key = 1'b1; tick(1); tick(5);
        view_key = 1'b1; tick(1); tick(3);
        // gesture ownership
        gesture_active = 1'b1; tick(6);
        gesture_active = 1'b0; tick(4);
        gesture_active = 1'b1; tick(3);
        // reminder during gesture, re-rise after two ticks extends the hold
        reminder = 1'b1; tick(2);
        repeat (2) begin sec_tick = 1'b1; tick(1); tick(2); end
        reminder = 1'b0; tick(1);
        reminder = 1'b1; tick(2);
        repeat (3) begin sec_tick = 1'b1; tick(1); tick(2); end
        tick(3);
        // power drop mid-hold, then a reminder edge while dark
        reminder = 1'b0; tick(1);
        reminder = 1'b1; tick(2);
        sec_tick = 1'b1; tick(1);
        power_state = 1'b0; tick(3);
        reminder = 1'b0; tick(1);
        reminder = 1'b1; tick(2);
        power_state = 1'b1; gesture_active = 1'b0; tick(8);
        // simultaneous reminder and gesture from base
        reminder = 1'b0; tick(1);
        reminder = 1'b1; gesture_active = 1'b1; tick(2);
        repeat (3) begin sec_tick = 1'b1; tick(1); tick(1); end
        tick(3);
        // asynchronous reset between edges
        @(posedge clk);
        #3 reset = 1'b1;
        #4 reset = 1'b0;
        tick(6);
        // randomized traffic
        repeat (3000) begin
            if (power_state) begin
                if ($urandom_range(0, 79) == 0) power_state = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                power_state = 1'b1;
            end
            view_key = ($urandom_range(0, 19) == 0);
            sec_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) gesture_active = ~gesture_active;
            if ($urandom_range(0, 24) == 0) reminder = ~reminder;
            if ($urandom_range(0, 7) == 0) begin
                src_clock   = $urandom;
                src_work    = $urandom;
                src_gesture = $urandom;
                src_remind  = $urandom;
            end
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                #3 reset = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
